// File: rtl/rsa_client_encryptor_if.sv
// Handshake and key-load bundle for the client-side RSA encryptor.
// slave = the encryptor, master = whoever feeds keys/messages and sinks ciphertext.
interface rsa_client_encryptor_if #(
    parameter int W       = 16,
    parameter int E_WIDTH = 8
);
    logic               key_load;
    logic [E_WIDTH-1:0] e_in;
    logic [W-1:0]       n_in;
    logic               key_valid;
    logic               msg_valid;
    logic [W-1:0]       msg_in;
    logic               msg_ready;
    logic               cipher_valid;
    logic [W-1:0]       cipher_out;
    logic               cipher_err;
    logic               cipher_ready;
    logic               busy;

    modport slave (
        input  key_load, e_in, n_in, msg_valid, msg_in, cipher_ready,
        output key_valid, msg_ready, cipher_valid, cipher_out, cipher_err, busy
    );

    modport master (
        output key_load, e_in, n_in, msg_valid, msg_in, cipher_ready,
        input  key_valid, msg_ready, cipher_valid, cipher_out, cipher_err, busy
    );
endinterface

// File: rtl/rsa_client_encryptor.sv
// Client-side RSA encryptor: c = m^e mod n using constant-time right-to-left
// square-and-multiply. Each round runs two bit-serial interleaved modular
// multipliers in parallel (result*base and base*base), W cycles per round,
// so every valid word takes exactly E_WIDTH*W exponentiation cycles.
module rsa_client_encryptor #(
    parameter int W       = 16,
    parameter int E_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    rsa_client_encryptor_if.slave bus
);
    // Accumulators carry two spare bits so 2*acc and acc+a never wrap, even for n = 2^W-1.
    localparam int AW = W + 2;
    localparam int BW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam int SW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic [W-1:0]       n_q, n_d;
    logic               key_valid_q, key_valid_d;
    logic [W-1:0]       m_q, m_d;
    logic [W-1:0]       result_q, result_d;
    logic [W-1:0]       base_q, base_d;
    logic [AW-1:0]      accp_q, accp_d;
    logic [AW-1:0]      accs_q, accs_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [SW-1:0]      step_q, step_d;
    logic [W-1:0]       cipher_out_q, cipher_out_d;
    logic               cipher_err_q, cipher_err_d;

    logic [AW-1:0]      p_next;
    logic [AW-1:0]      s_next;

    // One MSB-first step of an interleaved modular multiply; keeps acc < n.
    function automatic logic [AW-1:0] mod_step(
        input logic [AW-1:0] acc,
        input logic [AW-1:0] a,
        input logic          b_bit,
        input logic [AW-1:0] n
    );
        logic [AW-1:0] t;
        t = {acc[AW-2:0], 1'b0};
        if (t >= n) t = t - n;
        if (b_bit)  t = t + a;
        if (t >= n) t = t - n;
        return t;
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            e_q          <= '0;
            n_q          <= '0;
            key_valid_q  <= 1'b0;
            m_q          <= '0;
            result_q     <= '0;
            base_q       <= '0;
            accp_q       <= '0;
            accs_q       <= '0;
            bit_q        <= '0;
            step_q       <= '0;
            cipher_out_q <= '0;
            cipher_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            n_q          <= n_d;
            key_valid_q  <= key_valid_d;
            m_q          <= m_d;
            result_q     <= result_d;
            base_q       <= base_d;
            accp_q       <= accp_d;
            accs_q       <= accs_d;
            bit_q        <= bit_d;
            step_q       <= step_d;
            cipher_out_q <= cipher_out_d;
            cipher_err_q <= cipher_err_d;
        end
    end

    // Next-state and datapath: key capture, operand load, multiply rounds, output hold.
    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        n_d          = n_q;
        key_valid_d  = key_valid_q;
        m_d          = m_q;
        result_d     = result_q;
        base_d       = base_q;
        accp_d       = accp_q;
        accs_d       = accs_q;
        bit_d        = bit_q;
        step_d       = step_q;
        cipher_out_d = cipher_out_q;
        cipher_err_d = cipher_err_q;

        // Both multipliers scan the same operand bit of the round-start base.
        p_next = mod_step(accp_q, AW'(result_q), base_q[step_q], AW'(n_q));
        s_next = mod_step(accs_q, AW'(base_q),   base_q[step_q], AW'(n_q));

        case (state_q)
            S_IDLE: begin
                if (bus.key_load) begin
                    e_d         = bus.e_in;
                    n_d         = bus.n_in;
                    key_valid_d = (bus.n_in >= W'(2));
                end
                if (bus.msg_valid && key_valid_q) begin
                    m_d     = bus.msg_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (m_q >= n_q) begin
                    cipher_out_d = '0;
                    cipher_err_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    result_d     = W'(1);
                    base_d       = m_q;
                    bit_d        = '0;
                    step_d       = SW'(W - 1);
                    accp_d       = '0;
                    accs_d       = '0;
                    cipher_err_d = 1'b0;
                    state_d      = S_EXP;
                end
            end
            S_EXP: begin
                if (step_q == '0) begin
                    // Round boundary: square always advances, product kept only for set exponent bits.
                    base_d = s_next[W-1:0];
                    if (e_q[bit_q]) result_d = p_next[W-1:0];
                    accp_d = '0;
                    accs_d = '0;
                    step_d = SW'(W - 1);
                    if (bit_q == BW'(E_WIDTH - 1)) begin
                        cipher_out_d = e_q[bit_q] ? p_next[W-1:0] : result_q;
                        cipher_err_d = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    accp_d = p_next;
                    accs_d = s_next;
                    step_d = step_q - SW'(1);
                end
            end
            S_DONE: begin
                if (bus.cipher_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.key_valid    = key_valid_q;
    assign bus.msg_ready    = (state_q == S_IDLE) && key_valid_q;
    assign bus.cipher_valid = (state_q == S_DONE);
    assign bus.cipher_out   = cipher_out_q;
    assign bus.cipher_err   = cipher_err_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule
